// File: rtl/vend_pkg.sv
// Shared definitions for the change dispenser.
// Holds the FSM state codes, the tube index constants, the denomination table
// and the change datapath width.
package vend_pkg;

  localparam int unsigned CHANGE_W  = 8;
  localparam int unsigned NUM_TUBES = 4;
  localparam int unsigned TUBE_W    = 2;
  localparam int unsigned STATE_W   = 2;

  // Dispenser FSM states
  localparam logic [STATE_W-1:0] ST_IDLE   = 2'd0;
  localparam logic [STATE_W-1:0] ST_SELECT = 2'd1;
  localparam logic [STATE_W-1:0] ST_REQ    = 2'd2;
  localparam logic [STATE_W-1:0] ST_FINISH = 2'd3;

  // Tube indices, ordered largest denomination first so that the lowest
  // usable index is always the greedy choice.
  localparam logic [TUBE_W-1:0] TUBE_10 = 2'd0;
  localparam logic [TUBE_W-1:0] TUBE_5  = 2'd1;
  localparam logic [TUBE_W-1:0] TUBE_2  = 2'd2;
  localparam logic [TUBE_W-1:0] TUBE_1  = 2'd3;

  // Coin value held in each tube, in change units
  function automatic logic [CHANGE_W-1:0] coin_value(input logic [TUBE_W-1:0] tube);
    logic [CHANGE_W-1:0] val;
    case (tube)
      TUBE_10: val = 8'd10;
      TUBE_5:  val = 8'd5;
      TUBE_2:  val = 8'd2;
      default: val = 8'd1;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/coin_inventory.sv
// Per-tube coin inventory for the change dispenser.
// Four saturating counters, loaded with INV_INIT on reset, incremented by
// refills and decremented by one for every confirmed ejection.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   refill_en         add refill_cnt coins to tube refill_sel (saturating)
//   refill_sel        tube receiving the refill
//   refill_cnt        number of coins added
//   dec_en            one coin left tube dec_sel
//   dec_sel           tube that dropped the coin
//   avail             per-tube flag: tube holds at least one coin
module coin_inventory
  import vend_pkg::*;
#(
  parameter int unsigned INV_W    = 6,
  parameter int unsigned INV_INIT = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 refill_en,
  input  logic [TUBE_W-1:0]    refill_sel,
  input  logic [INV_W-1:0]     refill_cnt,
  input  logic                 dec_en,
  input  logic [TUBE_W-1:0]    dec_sel,
  output logic [NUM_TUBES-1:0] avail
);

  localparam logic [INV_W-1:0] INV_MAX = '1;
  localparam logic [INV_W-1:0] INV_RST = INV_W'(INV_INIT);
  localparam logic [INV_W-1:0] INV_ONE = INV_W'(1);

  logic [INV_W-1:0] inv   [NUM_TUBES];
  logic [INV_W-1:0] inv_d [NUM_TUBES];
  logic [INV_W:0]   sum   [NUM_TUBES];

  // Next count per tube; the extra sum bit flags a refill overflow
  always_comb begin
    for (int t = 0; t < NUM_TUBES; t++) begin
      sum[t]   = {1'b0, inv[t]} + {1'b0, refill_cnt};
      inv_d[t] = inv[t];
      if (refill_en && (refill_sel == TUBE_W'(t))) begin
        inv_d[t] = sum[t][INV_W] ? INV_MAX : sum[t][INV_W-1:0];
      end else if (dec_en && (dec_sel == TUBE_W'(t)) && (inv[t] != '0)) begin
        inv_d[t] = inv[t] - INV_ONE;
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int t = 0; t < NUM_TUBES; t++) inv[t] <= INV_RST;
    end else begin
      for (int t = 0; t < NUM_TUBES; t++) inv[t] <= inv_d[t];
    end
  end

  // Tube availability for coin selection
  always_comb begin
    for (int t = 0; t < NUM_TUBES; t++) avail[t] = (inv[t] != '0);
  end

endmodule

// File: rtl/change_dispense_ctrl.sv
// Change dispense controller.
// Breaks a change amount into 10/5/2/1 unit coins greedily, drives the coin
// ejector one coin per req/ack handshake, tracks tube inventory and reports
// shortfall (inventory could not cover the change) or jam (ack timeout).
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   start, change_amt      begin dispensing change_amt units (ignored while busy)
//   eject_req, eject_sel   request one coin from tube eject_sel
//   eject_ack              ejector confirms the coin dropped
//   refill, refill_sel,
//   refill_cnt             add coins to a tube while not busy
//   busy                   dispense in progress
//   done                   one-cycle end-of-dispense pulse
//   shortfall, jam         status qualified by done
//   remaining              unpaid balance, valid with done
module change_dispense_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned INV_W       = 6,
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter int unsigned INV_INIT    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [CHANGE_W-1:0] change_amt,
  output logic                eject_req,
  output logic [TUBE_W-1:0]   eject_sel,
  input  logic                eject_ack,
  input  logic                refill,
  input  logic [TUBE_W-1:0]   refill_sel,
  input  logic [INV_W-1:0]    refill_cnt,
  output logic                busy,
  output logic                done,
  output logic                shortfall,
  output logic                jam,
  output logic [CHANGE_W-1:0] remaining
);

  localparam int unsigned     TMO_W      = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_EXPIRE = TMO_W'(ACK_TIMEOUT - 1);
  localparam logic [TMO_W-1:0] TMO_ONE    = TMO_W'(1);

  logic [STATE_W-1:0]   state_q, state_d;
  logic [CHANGE_W-1:0]  rem_q, rem_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic                 req_d;
  logic [TUBE_W-1:0]    sel_d;
  logic                 busy_d, done_d, short_d, jam_d;
  logic [CHANGE_W-1:0]  remaining_d;

  logic [NUM_TUBES-1:0] avail;
  logic                 pick_valid;
  logic [TUBE_W-1:0]    pick_sel;
  logic [CHANGE_W-1:0]  cur_value;
  logic                 start_acc;
  logic                 refill_en;
  logic                 dec_en;

  // Busy drops one cycle after the done pulse, so start/refill wait for it
  assign start_acc = start && (state_q == ST_IDLE) && !busy;
  assign refill_en = refill && !busy;
  assign dec_en    = (state_q == ST_REQ) && eject_ack;
  assign cur_value = coin_value(eject_sel);

  coin_inventory #(
    .INV_W    (INV_W),
    .INV_INIT (INV_INIT)
  ) u_inv (
    .clk        (clk),
    .reset      (reset),
    .refill_en  (refill_en),
    .refill_sel (refill_sel),
    .refill_cnt (refill_cnt),
    .dec_en     (dec_en),
    .dec_sel    (eject_sel),
    .avail      (avail)
  );

  // Greedy pick: lowest index (largest coin) that fits and is stocked
  always_comb begin
    pick_valid = 1'b0;
    pick_sel   = '0;
    for (int t = NUM_TUBES - 1; t >= 0; t--) begin
      if (avail[t] && (coin_value(TUBE_W'(t)) <= rem_q)) begin
        pick_valid = 1'b1;
        pick_sel   = TUBE_W'(t);
      end
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    tmo_d       = tmo_q;
    req_d       = eject_req;
    sel_d       = eject_sel;
    busy_d      = busy;
    done_d      = 1'b0;
    short_d     = shortfall;
    jam_d       = jam;
    remaining_d = remaining;

    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (start_acc) begin
          rem_d   = change_amt;
          short_d = 1'b0;
          jam_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = (change_amt == '0) ? ST_FINISH : ST_SELECT;
        end
      end

      ST_SELECT: begin
        busy_d = 1'b1;
        tmo_d  = '0;
        if (pick_valid) begin
          sel_d   = pick_sel;
          req_d   = 1'b1;
          state_d = ST_REQ;
        end else begin
          short_d = 1'b1;
          state_d = ST_FINISH;
        end
      end

      // Ack is checked first so an ack on the expiry cycle still pays
      ST_REQ: begin
        busy_d = 1'b1;
        if (eject_ack) begin
          req_d   = 1'b0;
          rem_d   = rem_q - cur_value;
          tmo_d   = '0;
          state_d = (rem_q == cur_value) ? ST_FINISH : ST_SELECT;
        end else if (tmo_q == TMO_EXPIRE) begin
          req_d   = 1'b0;
          jam_d   = 1'b1;
          tmo_d   = '0;
          state_d = ST_FINISH;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
        end
      end

      ST_FINISH: begin
        busy_d      = 1'b1;
        done_d      = 1'b1;
        remaining_d = rem_q;
        state_d     = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      rem_q     <= '0;
      tmo_q     <= '0;
      eject_req <= 1'b0;
      eject_sel <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      shortfall <= 1'b0;
      jam       <= 1'b0;
      remaining <= '0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      tmo_q     <= tmo_d;
      eject_req <= req_d;
      eject_sel <= sel_d;
      busy      <= busy_d;
      done      <= done_d;
      shortfall <= short_d;
      jam       <= jam_d;
      remaining <= remaining_d;
    end
  end

endmodule

// File: tb/tb_change_dispense_ctrl.sv
// Self-checking bench for change_dispense_ctrl: directed scenarios plus
// randomized dispenses checked against a greedy change model.
module tb_change_dispense_ctrl;

  localparam int unsigned INV_W       = 6;
  localparam int unsigned ACK_TIMEOUT = 16;
  localparam int unsigned INV_INIT    = 8;
  localparam int          INV_MAX     = (1 << INV_W) - 1;
  localparam int          BUDGET      = 600;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [7:0]       change_amt;
  logic             eject_req;
  logic [1:0]       eject_sel;
  logic             eject_ack;
  logic             refill;
  logic [1:0]       refill_sel;
  logic [INV_W-1:0] refill_cnt;
  logic             busy;
  logic             done;
  logic             shortfall;
  logic             jam;
  logic [7:0]       remaining;

  int errors = 0;
  int checks = 0;

  // Reference model state: coins per tube and tube denominations
  int m_inv [4];
  int denom [4] = '{10, 5, 2, 1};
  int exp_q [$];

  change_dispense_ctrl #(
    .INV_W       (INV_W),
    .ACK_TIMEOUT (ACK_TIMEOUT),
    .INV_INIT    (INV_INIT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .change_amt (change_amt),
    .eject_req  (eject_req),
    .eject_sel  (eject_sel),
    .eject_ack  (eject_ack),
    .refill     (refill),
    .refill_sel (refill_sel),
    .refill_cnt (refill_cnt),
    .busy       (busy),
    .done       (done),
    .shortfall  (shortfall),
    .jam        (jam),
    .remaining  (remaining)
  );

  always #5 clk = ~clk;

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b0; eject_ack = 1'b0; refill = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int d = 0; d < 4; d++) m_inv[d] = INV_INIT;
  endtask

  task automatic do_refill(input int sel, input int cnt);
    @(negedge clk);
    refill = 1'b1; refill_sel = 2'(sel); refill_cnt = INV_W'(cnt);
    @(negedge clk);
    refill = 1'b0;
    m_inv[sel] = (m_inv[sel] + cnt > INV_MAX) ? INV_MAX : m_inv[sel] + cnt;
  endtask

  // One dispense: model the greedy payout, act as the ejector, compare.
  // poke drives a start and a refill while busy; both must be ignored.
  task automatic do_dispense(input int amt, input bit no_ack, input bit poke);
    int  rem, plan_n, cyc, first_req, req_cycles, wait_n, wcnt, exp_t, pick;
    bit  sh, jm, prev_req, seen_done;
    exp_q.delete(); rem = amt; sh = 1'b0; jm = 1'b0;
    while (rem > 0) begin
      pick = -1;
      for (int d = 3; d >= 0; d--) if (denom[d] <= rem && m_inv[d] > 0) pick = d;
      if (pick < 0) begin sh = 1'b1; break; end
      exp_q.push_back(pick);
      if (no_ack) begin jm = 1'b1; break; end
      m_inv[pick]--; rem -= denom[pick];
    end
    plan_n = exp_q.size();

    @(negedge clk);
    start = 1'b1; change_amt = 8'(amt);
    cyc = 0; first_req = -1; req_cycles = 0; prev_req = 1'b0; seen_done = 1'b0;
    wait_n = 0; wcnt = 0;
    while (cyc < BUDGET && !seen_done) begin
      @(negedge clk);
      cyc++;
      start = 1'b0; eject_ack = 1'b0; refill = 1'b0;
      if (done) begin
        seen_done = 1'b1;
      end else if (eject_req) begin
        if (!prev_req) begin
          if (first_req < 0) first_req = cyc;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL coin_order amt=%0d: unexpected eject_sel=%0d, no coin expected", amt, eject_sel);
          end else begin
            exp_t = exp_q.pop_front();
            if (eject_sel !== 2'(exp_t)) begin
              errors++;
              $display("FAIL coin_order amt=%0d: eject_sel=%0d expected %0d", amt, eject_sel, exp_t);
            end
          end
          wait_n = $urandom_range(0, 3); wcnt = 0;
        end
        req_cycles++;
        if (!no_ack) begin
          if (wcnt == wait_n) eject_ack = 1'b1;
          else wcnt++;
        end
      end else if (!no_ack && $urandom_range(0, 3) == 0) begin
        eject_ack = 1'b1;
      end
      if (poke && cyc == 1) begin
        start = 1'b1; change_amt = 8'($urandom_range(1, 99));
        refill = 1'b1; refill_sel = 2'($urandom_range(0, 3));
        refill_cnt = INV_W'($urandom_range(1, INV_MAX));
      end
      prev_req = eject_req;
    end

    checks++;
    if (!seen_done) begin
      errors++;
      $display("FAIL done_timeout amt=%0d: no done within %0d cycles", amt, BUDGET);
    end else begin
      checks++;
      if (remaining !== 8'(rem)) begin
        errors++;
        $display("FAIL remaining amt=%0d: got %0d expected %0d", amt, remaining, rem);
      end
      checks++;
      if (shortfall !== sh || jam !== jm) begin
        errors++;
        $display("FAIL status amt=%0d: shortfall=%0b jam=%0b expected %0b %0b", amt, shortfall, jam, sh, jm);
      end
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL coin_count amt=%0d: %0d expected coins never requested", amt, exp_q.size());
      end
      if (jm) begin
        checks++;
        if (req_cycles != ACK_TIMEOUT) begin
          errors++;
          $display("FAIL jam_req_len amt=%0d: eject_req high %0d cycles expected %0d", amt, req_cycles, ACK_TIMEOUT);
        end
      end
      if (amt == 0) begin
        checks++;
        if (cyc != 2) begin
          errors++;
          $display("FAIL zero_latency: done %0d cycles after start expected 2", cyc);
        end
      end else if (plan_n > 0) begin
        checks++;
        if (first_req != 2) begin
          errors++;
          $display("FAIL req_latency amt=%0d: first eject_req %0d cycles after start expected 2", amt, first_req);
        end
      end
    end

    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL after_done amt=%0d: done=%0b busy=%0b expected 0 0", amt, done, busy);
    end
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (dut.u_inv.inv[d] !== INV_W'(m_inv[d])) begin
        errors++;
        $display("FAIL inventory tube%0d after amt=%0d: got %0d expected %0d", d, amt, dut.u_inv.inv[d], m_inv[d]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; change_amt = '0; eject_ack = 1'b0;
    refill = 1'b0; refill_sel = '0; refill_cnt = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({eject_req, eject_sel, busy, done, shortfall, jam, remaining} !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs: req=%0b sel=%0d busy=%0b done=%0b sh=%0b jam=%0b rem=%0d expected all 0",
               eject_req, eject_sel, busy, done, shortfall, jam, remaining);
    end
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (dut.u_inv.inv[d] !== INV_W'(INV_INIT)) begin
        errors++;
        $display("FAIL reset_inventory tube%0d: got %0d expected %0d", d, dut.u_inv.inv[d], INV_INIT);
      end
    end
    reset = 1'b0;
    for (int d = 0; d < 4; d++) m_inv[d] = INV_INIT;
  endtask

  task automatic test_full_18();
    apply_reset();
    do_dispense(18, 1'b0, 1'b0);
  endtask

  task automatic test_zero_change();
    do_dispense(0, 1'b0, 1'b0);
  endtask

  task automatic test_jam();
    apply_reset();
    do_dispense(5, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid();
    bit saw_req, saw_done;
    apply_reset();
    @(negedge clk);
    start = 1'b1; change_amt = 8'd18;
    saw_req = 1'b0;
    for (int i = 0; i < 10 && !saw_req; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (eject_req) saw_req = 1'b1;
    end
    checks++;
    if (!saw_req) begin
      errors++;
      $display("FAIL reset_mid_req: eject_req never rose, got 0 expected 1");
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (eject_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_outputs: req=%0b busy=%0b done=%0b expected 0 0 0", eject_req, busy, done);
    end
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (dut.u_inv.inv[d] !== INV_W'(INV_INIT)) begin
        errors++;
        $display("FAIL reset_mid_inventory tube%0d: got %0d expected %0d", d, dut.u_inv.inv[d], INV_INIT);
      end
    end
    reset = 1'b0;
    for (int d = 0; d < 4; d++) m_inv[d] = INV_INIT;
    saw_done = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL reset_mid_done: done pulsed after reset, got 1 expected 0");
    end
  endtask

  // Drain to tubes 0,0,1,1, then 7 units pays 2+1 and leaves 4 unpaid
  task automatic test_shortfall();
    apply_reset();
    do_dispense(80, 1'b0, 1'b0);
    do_dispense(40, 1'b0, 1'b0);
    do_dispense(16, 1'b0, 1'b0);
    do_dispense(7, 1'b0, 1'b0);
    do_refill(2, 1);
    do_dispense(7, 1'b0, 1'b0);
  endtask

  task automatic test_saturation();
    apply_reset();
    do_refill(0, 63);
    checks++;
    if (dut.u_inv.inv[0] !== INV_W'(INV_MAX)) begin
      errors++;
      $display("FAIL refill_saturate: tube0 got %0d expected %0d", dut.u_inv.inv[0], INV_MAX);
    end
    do_dispense(23, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 2) == 0) do_refill($urandom_range(0, 3), $urandom_range(0, 20));
      do_dispense($urandom_range(0, 60), 1'b0, bit'($urandom_range(0, 1)));
    end
    do_dispense($urandom_range(1, 30), 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) do_dispense($urandom_range(0, 40), 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_full_18();
    test_zero_change();
    test_jam();
    test_reset_mid();
    test_shortfall();
    test_saturation();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
